// File: rtl/gpu_host_controller.sv
// Host command front-end: single/burst memory copies, heap bump allocator and
// kernel launch with cycle counting, one command in flight at a time.
module gpu_host_controller #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter int          LEN_WIDTH  = 16,
  parameter int unsigned HEAP_BASE  = 1024,
  parameter int unsigned HEAP_END   = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_arg,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  rsp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] core_pc,
  output logic                  core_run,
  input  logic                  core_halt,
  output logic                  busy
);
  localparam int STEP = DATA_WIDTH / 8;
  // Allocator arithmetic is wide enough that neither the rounding nor the sum can wrap.
  localparam int SW   = ((ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH) + 2;

  typedef enum logic [2:0] {S_IDLE, S_MEM_REQ, S_IN_WAIT, S_RSP, S_RUN} state_t;
  typedef enum logic [2:0] {
    OP_NOP, OP_WRITE, OP_READ_BURST, OP_WRITE_BURST,
    OP_ALLOC, OP_FREE_ALL, OP_LAUNCH, OP_ILLEGAL
  } op_t;

  typedef struct packed {
    op_t                   op;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
  } cmd_t;

  state_t                state, state_nxt;
  cmd_t                  cmd;
  op_t                   op_in;
  logic [LEN_WIDTH-1:0]  arg_len, remain;
  logic [ADDR_WIDTH-1:0] heap_ptr, core_pc_q;
  logic [DATA_WIDTH-1:0] cycles, cyc_inc;
  logic [DATA_WIDTH-1:0] rsp_data_q, mem_wdata_q;
  logic                  rsp_last_q, rsp_err_q, mem_we_q;
  logic [SW-1:0]         alloc_size, alloc_end;
  logic                  alloc_ok;

  assign op_in      = op_t'(cmd_op);
  assign arg_len    = cmd_arg[LEN_WIDTH-1:0];
  assign alloc_size = (SW'(cmd_arg) + SW'(STEP - 1)) & ~SW'(STEP - 1);
  assign alloc_end  = SW'(heap_ptr) + alloc_size;
  assign alloc_ok   = alloc_end <= SW'(HEAP_END);
  assign cyc_inc    = (&cycles) ? cycles : cycles + DATA_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (cmd_valid) begin
        unique case (op_in)
          OP_WRITE:       state_nxt = S_MEM_REQ;
          OP_READ_BURST:  state_nxt = (arg_len == '0) ? S_RSP : S_MEM_REQ;
          OP_WRITE_BURST: state_nxt = (arg_len == '0) ? S_RSP : S_IN_WAIT;
          OP_LAUNCH:      state_nxt = S_RUN;
          default:        state_nxt = S_RSP;
        endcase
      end
      S_MEM_REQ: if (mem_ack)
        state_nxt = (cmd.op == OP_WRITE_BURST && remain != LEN_WIDTH'(1)) ? S_IN_WAIT : S_RSP;
      S_IN_WAIT: if (in_valid)  state_nxt = S_MEM_REQ;
      // A read burst fetches its next word only once the current beat is taken.
      S_RSP: if (rsp_ready)
        state_nxt = (cmd.op == OP_READ_BURST && !rsp_last_q) ? S_MEM_REQ : S_IDLE;
      S_RUN: if (core_halt) state_nxt = S_RSP;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    rsp_valid = 1'b0;
    mem_req   = 1'b0;
    core_run  = 1'b0;
    unique case (state)
      S_IDLE:    cmd_ready = ~rst;
      S_MEM_REQ: mem_req   = 1'b1;
      S_IN_WAIT: in_ready  = 1'b1;
      S_RSP:     rsp_valid = 1'b1;
      S_RUN:     core_run  = 1'b1;
      default:   ;
    endcase
  end

  assign busy      = state != S_IDLE;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_err   = rsp_err_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = mem_wdata_q;
  assign core_pc   = core_pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd         <= '0;
      remain      <= '0;
      heap_ptr    <= ADDR_WIDTH'(HEAP_BASE);
      core_pc_q   <= '0;
      cycles      <= '0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (cmd_valid) begin
          cmd         <= '{op: op_in, addr: cmd_addr & ~ADDR_WIDTH'(STEP - 1), len: arg_len};
          remain      <= arg_len;
          rsp_data_q  <= '0;
          rsp_last_q  <= 1'b1;
          rsp_err_q   <= 1'b0;
          mem_we_q    <= op_in == OP_WRITE;
          mem_wdata_q <= cmd_arg;
          cycles      <= '0;
          unique case (op_in)
            OP_ALLOC: begin
              if (alloc_ok) begin
                rsp_data_q <= DATA_WIDTH'(heap_ptr);
                heap_ptr   <= heap_ptr + ADDR_WIDTH'(alloc_size);
              end else begin
                rsp_err_q  <= 1'b1;
              end
            end
            OP_FREE_ALL: heap_ptr  <= ADDR_WIDTH'(HEAP_BASE);
            OP_LAUNCH:   core_pc_q <= cmd_addr;
            OP_ILLEGAL:  rsp_err_q <= 1'b1;
            default:     ;
          endcase
        end
        S_MEM_REQ: if (mem_ack) begin
          remain   <= remain - LEN_WIDTH'(1);
          cmd.addr <= cmd.addr + ADDR_WIDTH'(STEP);
          if (cmd.op == OP_READ_BURST) begin
            rsp_data_q <= mem_rdata;
            rsp_last_q <= remain == LEN_WIDTH'(1);
          end else if (cmd.op == OP_WRITE_BURST) begin
            rsp_data_q <= DATA_WIDTH'(cmd.len);
          end
        end
        S_IN_WAIT: if (in_valid) begin
          mem_wdata_q <= in_data;
          mem_we_q    <= 1'b1;
        end
        S_RUN: begin
          cycles <= cyc_inc;
          if (core_halt) rsp_data_q <= cyc_inc;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gpu_host_controller.sv
// Directed bench for gpu_host_controller: a small memory responder plus
// per-feature tasks with hand-computed expectations.
module tb_gpu_host_controller;
  localparam logic [2:0] NOP = 3'd0, WRITE = 3'd1, RD_BURST = 3'd2, WR_BURST = 3'd3,
                         ALLOC = 3'd4, FREE_ALL = 3'd5, LAUNCH = 3'd6, ILLEGAL = 3'd7;

  logic        clk = 0, rst = 1;
  logic        cmd_valid = 0, cmd_ready;
  logic [2:0]  cmd_op = 0;
  logic [31:0] cmd_addr = 0, cmd_arg = 0;
  logic        in_valid = 0, in_ready;
  logic [31:0] in_data = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_last, rsp_err;
  logic [31:0] rsp_data;
  logic        mem_req, mem_we, mem_ack = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [31:0] core_pc;
  logic        core_run, core_halt = 0, busy;

  int n_tests = 0, n_fail = 0;
  int ack_delay = 0, wait_cnt = 0, req_cycles = 0;
  logic [31:0] mem_model [256];
  logic [31:0] log_addr[$], log_data[$];

  gpu_host_controller dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_arg(cmd_arg),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .core_pc(core_pc), .core_run(core_run), .core_halt(core_halt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory responder: one-cycle ack after ack_delay waiting cycles, logs writes.
  always @(negedge clk) begin
    if (rst) begin
      mem_ack = 0;
      wait_cnt = 0;
    end else if (mem_ack) begin
      mem_ack = 0;
    end else if (mem_req) begin
      req_cycles++;
      if (wait_cnt >= ack_delay) begin
        wait_cnt = 0;
        mem_ack = 1;
        if (mem_we) begin
          mem_model[mem_addr[9:2]] = mem_wdata;
          log_addr.push_back(mem_addr);
          log_data.push_back(mem_wdata);
        end else begin
          mem_rdata = mem_model[mem_addr[9:2]];
        end
      end else begin
        wait_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, need $finish before 500us");
    $fatal(1);
  end

  task automatic send_cmd(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] arg);
    int t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      n_tests++; n_fail++;
      $display("FAIL cmd_timeout op=%0d: cmd_ready=0, need 1", op);
    end
    cmd_valid = 1; cmd_op = op; cmd_addr = addr; cmd_arg = arg;
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic feed_beat(input logic [31:0] d);
    int t = 0;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL in_timeout: in_ready=0, need 1");
    end
    in_valid = 1; in_data = d;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic get_rsp(input bit stall, output logic [31:0] d, output logic l,
                         output logic e, output logic held);
    int t = 0;
    while (!rsp_valid && t < 200) begin @(negedge clk); t++; end
    if (!rsp_valid) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_timeout: rsp_valid=0, need 1");
    end
    d = rsp_data; l = rsp_last; e = rsp_err; held = 1;
    if (stall) begin
      @(negedge clk);
      held = rsp_valid && rsp_data === d && rsp_last === l && rsp_err === e;
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({cmd_ready, in_ready, rsp_valid, mem_req, core_run, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, need 000000", {cmd_ready, in_ready, rsp_valid, mem_req, core_run, busy});
    end
    n_tests++;
    if (core_pc !== 32'h0 || rsp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: core_pc=%h rsp_data=%h, need 0/0", core_pc, rsp_data);
    end
    rst = 0;
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b, need 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_write;
    logic [31:0] d; logic l, e, h;
    log_addr.delete(); log_data.delete(); ack_delay = 0;
    send_cmd(WRITE, 32'h100, 32'hDEADBEEF);
    get_rsp(0, d, l, e, h);
    n_tests++;
    if (log_addr.size() != 1 || log_addr[0] !== 32'h100 || log_data[0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write_mem: %0d writes, first addr=%h data=%h, need 1 write 100/deadbeef",
               log_addr.size(), (log_addr.size() > 0) ? log_addr[0] : 32'hx, (log_data.size() > 0) ? log_data[0] : 32'hx);
    end
    n_tests++;
    if ({d, l, e} !== {32'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL write_rsp: data=%h last=%b err=%b, need 0/1/0", d, l, e);
    end
  endtask

  task automatic test_bursts;
    logic [31:0] d; logic l, e, h;
    logic [31:0] exp_a [3] = '{32'h200, 32'h204, 32'h208};
    log_addr.delete(); log_data.delete(); ack_delay = 2;
    send_cmd(WR_BURST, 32'h200, 32'd3);
    for (int i = 1; i <= 3; i++) feed_beat(32'(i));
    get_rsp(0, d, l, e, h);
    n_tests++;
    if (log_addr.size() != 3) begin
      n_fail++;
      $display("FAIL wburst_count: %0d writes, need 3", log_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (log_addr[i] !== exp_a[i] || log_data[i] !== 32'(i + 1)) begin
          n_fail++;
          $display("FAIL wburst_beat%0d: addr=%h data=%h, need %h/%h", i, log_addr[i], log_data[i], exp_a[i], i + 1);
        end
      end
    end
    n_tests++;
    if ({d, l, e} !== {32'd3, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL wburst_rsp: data=%h last=%b err=%b, need 3/1/0", d, l, e);
    end
    ack_delay = 0;
    send_cmd(RD_BURST, 32'h200, 32'd3);
    for (int i = 0; i < 3; i++) begin
      get_rsp(i != 1, d, l, e, h);
      n_tests++;
      if ({d, l, e, h} !== {32'(i + 1), i == 2, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL rburst_beat%0d: data=%h last=%b err=%b held=%b, need %h/%b/0/1", i, d, l, e, h, i + 1, i == 2);
      end
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rburst_idle: busy=%b, need 0", busy);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] d; logic l, e, h;
    log_addr.delete(); log_data.delete();
    send_cmd(WR_BURST, 32'hFFFF_FFFE, 32'd2);
    feed_beat(32'hA5);
    feed_beat(32'h5A);
    get_rsp(0, d, l, e, h);
    n_tests++;
    if (log_addr.size() != 2 || log_addr[0] !== 32'hFFFF_FFFC || log_addr[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_addr: %0d writes, addrs=%h/%h, need fffffffc/00000000", log_addr.size(),
               (log_addr.size() > 0) ? log_addr[0] : 32'hx, (log_addr.size() > 1) ? log_addr[1] : 32'hx);
    end
  endtask

  task automatic test_alloc;
    logic [31:0] d; logic l, e, h;
    logic [31:0] sz   [8] = '{5, 8, 4000, 4, 0, 4, 3068, 1};
    logic [2:0]  op   [8] = '{ALLOC, ALLOC, ALLOC, ALLOC, FREE_ALL, ALLOC, ALLOC, ALLOC};
    logic [31:0] exp_d[8] = '{1024, 1032, 0, 1040, 0, 1024, 1028, 0};
    logic        exp_e[8] = '{0, 0, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 8; i++) begin
      send_cmd(op[i], 32'h0, sz[i]);
      get_rsp(0, d, l, e, h);
      n_tests++;
      if ({d, l, e} !== {exp_d[i], 1'b1, exp_e[i]}) begin
        n_fail++;
        $display("FAIL alloc_step%0d: data=%0d last=%b err=%b, need %0d/1/%b", i, d, l, e, exp_d[i], exp_e[i]);
      end
    end
  endtask

  task automatic test_launch;
    logic [31:0] d; logic l, e, h;
    int cnt = 0, t = 0;
    send_cmd(LAUNCH, 32'h40, 32'h0);
    n_tests++;
    if (core_run !== 1'b1 || core_pc !== 32'h40) begin
      n_fail++;
      $display("FAIL launch_start: core_run=%b core_pc=%h, need 1/00000040", core_run, core_pc);
    end
    while (t < 100) begin
      if (core_run) cnt++;
      if (cnt == 10) break;
      @(negedge clk); t++;
    end
    core_halt = 1;
    @(negedge clk);
    core_halt = 0;
    n_tests++;
    if (core_run !== 1'b0) begin
      n_fail++;
      $display("FAIL launch_stop: core_run=%b, need 0", core_run);
    end
    get_rsp(0, d, l, e, h);
    n_tests++;
    if ({d, l, e} !== {32'd10, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL launch_rsp: data=%0d last=%b err=%b, need 10/1/0", d, l, e);
    end
  endtask

  task automatic test_corner_ops;
    logic [31:0] d; logic l, e, h;
    logic [2:0]  op   [4] = '{RD_BURST, WR_BURST, ILLEGAL, NOP};
    logic        exp_e[4] = '{0, 0, 1, 0};
    int base = req_cycles;
    for (int i = 0; i < 4; i++) begin
      send_cmd(op[i], 32'h300, 32'h0);
      get_rsp(0, d, l, e, h);
      n_tests++;
      if ({d, l, e} !== {32'h0, 1'b1, exp_e[i]}) begin
        n_fail++;
        $display("FAIL corner_op%0d: data=%h last=%b err=%b, need 0/1/%b", op[i], d, l, e, exp_e[i]);
      end
    end
    n_tests++;
    if (req_cycles != base) begin
      n_fail++;
      $display("FAIL len0_no_mem: %0d mem_req cycles, need 0", req_cycles - base);
    end
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] d; logic l, e, h;
    int t = 0;
    log_addr.delete(); log_data.delete(); ack_delay = 5;
    send_cmd(WR_BURST, 32'h300, 32'd2);
    feed_beat(32'hAA);
    while (!mem_req && t < 50) begin @(negedge clk); t++; end
    rst = 1;
    #1;
    n_tests++;
    if ({mem_req, rsp_valid, core_run, busy, cmd_ready} !== 5'b0) begin
      n_fail++;
      $display("FAIL midop_reset: req/rsp/run/busy/rdy=%b, need 00000", {mem_req, rsp_valid, core_run, busy, cmd_ready});
    end
    @(negedge clk);
    rst = 0;
    ack_delay = 0;
    #1;
    n_tests++;
    if (cmd_ready !== 1'b1 || log_addr.size() != 0) begin
      n_fail++;
      $display("FAIL midop_release: cmd_ready=%b writes=%0d, need 1/0", cmd_ready, log_addr.size());
    end
    send_cmd(ALLOC, 32'h0, 32'd4);
    get_rsp(0, d, l, e, h);
    n_tests++;
    if ({d, e} !== {32'd1024, 1'b0}) begin
      n_fail++;
      $display("FAIL midop_heap: data=%0d err=%b, need 1024/0", d, e);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = '0;
    test_reset();
    test_write();
    test_bursts();
    test_wrap();
    test_alloc();
    test_launch();
    test_corner_ops();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
